// File: rtl/test_run_controller_if.sv
// Harness-side bundle for test_run_controller.
//   plus_enable  : test enable flag from a plusarg flag reader
//   plus_timeout : max run cycles, 0 disables the timeout
//   dut_done     : DUT completion level, only looked at while running
//   dut_fail     : DUT failure level, only looked at while running
//   start        : one-cycle pulse releasing the DUT
//   running      : high while the DUT is being timed
//   finish       : sticky, test resolved
//   pass         : sticky result, valid when finish=1
//   timeout      : sticky result, valid when finish=1
//   cycles       : run cycles elapsed, frozen once finish=1
// master = harness side, slave = controller side.
interface test_run_controller_if #(
  parameter int CNT_W = 32
);
  logic             plus_enable;
  logic [CNT_W-1:0] plus_timeout;
  logic             dut_done;
  logic             dut_fail;
  logic             start;
  logic             running;
  logic             finish;
  logic             pass;
  logic             timeout;
  logic [CNT_W-1:0] cycles;

  modport master (
    output plus_enable, plus_timeout, dut_done, dut_fail,
    input  start, running, finish, pass, timeout, cycles
  );

  modport slave (
    input  plus_enable, plus_timeout, dut_done, dut_fail,
    output start, running, finish, pass, timeout, cycles
  );
endinterface

// File: rtl/test_run_controller.sv
// Test-sequencing controller for simulation harnesses.
// Samples the enable flag and timeout once out of reset, waits START_DELAY
// cycles, pulses start, then times the DUT run and resolves it as pass,
// fail or timeout with sticky result flags.  With plus_enable tied low the
// block parks in DISABLED and every output stays 0.
// Ports:
//   clock : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : harness bundle (slave modport), see test_run_controller_if
// Parameters:
//   CNT_W       : width of timeout value and cycle counter
//   START_DELAY : cycles spent in DELAY before start (1..2^16-1)
module test_run_controller #(
  parameter int CNT_W       = 32,
  parameter int START_DELAY = 16
) (
  input logic                   clock,
  input logic                   reset,
  test_run_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    DISABLED,
    DELAY,
    START,
    RUN,
    DONE
  } state_t;

  localparam logic [15:0]      DLY_LAST = 16'(START_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Saturating increment: the cycle counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [15:0]      dly_cnt_q, dly_cnt_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic             start_q, start_d;
  logic             running_q, running_d;
  logic             finish_q, finish_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cyc_inc;

  assign cyc_inc = sat_inc(cycles_q);

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      dly_cnt_q <= '0;
      tmo_q     <= '0;
      cycles_q  <= '0;
      start_q   <= 1'b0;
      running_q <= 1'b0;
      finish_q  <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_cnt_q <= dly_cnt_d;
      tmo_q     <= tmo_d;
      cycles_q  <= cycles_d;
      start_q   <= start_d;
      running_q <= running_d;
      finish_q  <= finish_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d   = state_q;
    dly_cnt_d = dly_cnt_q;
    tmo_d     = tmo_q;
    cycles_d  = cycles_q;
    start_d   = 1'b0;
    running_d = running_q;
    finish_d  = finish_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;

    case (state_q)
      IDLE: begin
        // Only chance to capture the timeout; later changes are ignored.
        if (bus.plus_enable) begin
          state_d   = DELAY;
          tmo_d     = bus.plus_timeout;
          dly_cnt_d = '0;
        end else begin
          state_d = DISABLED;
        end
      end

      DISABLED: begin
        state_d = DISABLED;
      end

      DELAY: begin
        // Counter runs 0..START_DELAY-1, one DELAY cycle per value.
        if (dly_cnt_q == DLY_LAST) begin
          state_d = START;
          start_d = 1'b1;
        end else begin
          dly_cnt_d = dly_cnt_q + 16'd1;
        end
      end

      START: begin
        state_d   = RUN;
        running_d = 1'b1;
        cycles_d  = '0;
      end

      RUN: begin
        // Fail beats done, and either beats a timeout in the same cycle.
        // A resolving done/fail cycle is not counted.
        if (bus.dut_fail) begin
          state_d   = DONE;
          running_d = 1'b0;
          finish_d  = 1'b1;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
        end else if (bus.dut_done) begin
          state_d   = DONE;
          running_d = 1'b0;
          finish_d  = 1'b1;
          pass_d    = 1'b1;
          timeout_d = 1'b0;
        end else begin
          cycles_d = cyc_inc;
          if ((tmo_q != '0) && (cyc_inc == tmo_q)) begin
            state_d   = DONE;
            running_d = 1'b0;
            finish_d  = 1'b1;
            pass_d    = 1'b0;
            timeout_d = 1'b1;
          end
        end
      end

      DONE: begin
        state_d   = DONE;
        running_d = 1'b0;
        finish_d  = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.start   = start_q;
  assign bus.running = running_q;
  assign bus.finish  = finish_q;
  assign bus.pass    = pass_q;
  assign bus.timeout = timeout_q;
  assign bus.cycles  = cycles_q;

  a_start_not_running: assert property (@(posedge clock) disable iff (reset)
    !(start_q && running_q));
  a_finish_not_running: assert property (@(posedge clock) disable iff (reset)
    !(finish_q && running_q));
  a_pass_not_timeout: assert property (@(posedge clock) disable iff (reset)
    !(pass_q && timeout_q));

endmodule

// File: tb/tb_test_run_controller.sv
// Directed bench for test_run_controller: a vector table of complete test
// runs on a CNT_W=32 / START_DELAY=16 instance, plus hand-written sequences
// for the disabled path, reset during a run and counter saturation on a
// CNT_W=4 / START_DELAY=3 instance.
module tb_test_run_controller;

  logic clock = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clock = ~clock;

  test_run_controller_if #(.CNT_W(32)) bus_a();
  test_run_controller_if #(.CNT_W(4))  bus_b();

  test_run_controller #(.CNT_W(32), .START_DELAY(16)) dut_a (
    .clock (clock),
    .reset (rst_a),
    .bus   (bus_a.slave)
  );

  test_run_controller #(.CNT_W(4), .START_DELAY(3)) dut_b (
    .clock (clock),
    .reset (rst_b),
    .bus   (bus_b.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] tmo;
    int          done_at;   // RUN cycle carrying dut_done, 0 = never
    int          fail_at;   // RUN cycle carrying dut_fail, 0 = never
    logic        exp_pass;
    logic        exp_tmo;
    logic [31:0] exp_cycles;
    int          exp_run;   // RUN cycles until resolution
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [4:0] flags_a();
    return {bus_a.start, bus_a.running, bus_a.finish, bus_a.pass, bus_a.timeout};
  endfunction

  // Hold reset two cycles, check the reset state, release just after an edge.
  task automatic reset_a(input string name, input logic en, input logic [31:0] tmo);
    rst_a = 1'b1;
    bus_a.plus_enable  = en;
    bus_a.plus_timeout = tmo;
    bus_a.dut_done     = 1'b0;
    bus_a.dut_fail     = 1'b0;
    tick();
    tick();
    chk({name, ".rst_flags"}, 64'(flags_a()), 64'd0);
    chk({name, ".rst_cycles"}, 64'(bus_a.cycles), 64'd0);
    rst_a = 1'b0;
  endtask

  // Count edges after reset release until start appears (bounded).
  task automatic wait_start_a(input string name);
    int e;
    e = 0;
    while (e < 100) begin
      tick();
      e++;
      if (bus_a.start === 1'b1) break;
    end
    chk({name, ".start_lat"}, 64'(e), 64'd17);
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    bit fin;
    reset_a(v.name, 1'b1, v.tmo);
    wait_start_a(v.name);
    tick();
    chk({v.name, ".start_once"}, 64'({bus_a.start, bus_a.running}), 64'b01);
    k = 0;
    fin = 1'b0;
    while (k < 200 && !fin) begin
      k++;
      bus_a.dut_done = (k == v.done_at);
      bus_a.dut_fail = (k == v.fail_at);
      tick();
      fin = bus_a.finish;
    end
    bus_a.dut_done = 1'b0;
    bus_a.dut_fail = 1'b0;
    chk({v.name, ".run_len"}, 64'(k), 64'(v.exp_run));
    chk({v.name, ".flags"}, 64'(flags_a()), 64'({3'b001, v.exp_pass, v.exp_tmo}));
    chk({v.name, ".cycles"}, 64'(bus_a.cycles), 64'(v.exp_cycles));
    // DONE ignores DUT activity
    bus_a.dut_done = 1'b1;
    bus_a.dut_fail = 1'b1;
    tick();
    tick();
    bus_a.dut_done = 1'b0;
    bus_a.dut_fail = 1'b0;
    chk({v.name, ".held_flags"}, 64'(flags_a()), 64'({3'b001, v.exp_pass, v.exp_tmo}));
    chk({v.name, ".held_cycles"}, 64'(bus_a.cycles), 64'(v.exp_cycles));
  endtask

  initial begin
    int bad;
    int e;
    bit fin;
    int k;

    bus_a.plus_enable  = 1'b0;
    bus_a.plus_timeout = '0;
    bus_a.dut_done     = 1'b0;
    bus_a.dut_fail     = 1'b0;
    bus_b.plus_enable  = 1'b1;
    bus_b.plus_timeout = '0;
    bus_b.dut_done     = 1'b0;
    bus_b.dut_fail     = 1'b0;

    //           name          tmo  done fail pass tmo cycles run
    vecs[0] = '{"pass_to100",  100, 10,  0,   1,   0,  9,     10};
    vecs[1] = '{"timeout5",    5,   0,   0,   0,   1,  5,     5};
    vecs[2] = '{"both_at5",    5,   5,   5,   0,   0,  4,     5};
    vecs[3] = '{"done_at5",    5,   5,   0,   1,   0,  4,     5};
    vecs[4] = '{"fail_noto",   0,   0,   3,   0,   0,  2,     3};
    vecs[5] = '{"timeout1",    1,   0,   0,   0,   1,  1,     1};

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Disabled: enable low at IDLE, later high, DUT activity ignored.
    reset_a("disabled", 1'b0, 32'd100);
    tick();
    bus_a.plus_enable = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      bus_a.dut_done = ((i % 50) == 10);
      tick();
      if (flags_a() != 5'd0 || bus_a.cycles != 32'd0) bad++;
    end
    bus_a.dut_done = 1'b0;
    chk("disabled.quiet_cycles", 64'(bad), 64'd0);

    // Reset during RUN, timeout changed mid-run takes effect afterwards.
    reset_a("midrun", 1'b1, 32'd100);
    wait_start_a("midrun");
    tick();
    repeat (7) tick();
    chk("midrun.cycles7", 64'(bus_a.cycles), 64'd7);
    chk("midrun.running", 64'(bus_a.running), 64'd1);
    bus_a.plus_timeout = 32'd3;
    #2;
    rst_a = 1'b1;
    #1;
    chk("midrun.async_flags", 64'(flags_a()), 64'd0);
    chk("midrun.async_cycles", 64'(bus_a.cycles), 64'd0);
    tick();
    rst_a = 1'b0;
    wait_start_a("rerun");
    tick();
    k = 0;
    fin = 1'b0;
    while (k < 200 && !fin) begin
      k++;
      tick();
      fin = bus_a.finish;
    end
    chk("rerun.run_len", 64'(k), 64'd3);
    chk("rerun.flags", 64'(flags_a()), 64'b00101);
    chk("rerun.cycles", 64'(bus_a.cycles), 64'd3);

    // Reset while start is high clears it immediately.
    reset_a("start_rst", 1'b1, 32'd100);
    wait_start_a("start_rst");
    rst_a = 1'b1;
    #1;
    chk("start_rst.start_cleared", 64'(bus_a.start), 64'd0);
    tick();
    rst_a = 1'b0;

    // Saturation on the 4-bit instance, no timeout.
    tick();
    rst_b = 1'b0;
    e = 0;
    while (e < 100) begin
      tick();
      e++;
      if (bus_b.start === 1'b1) break;
    end
    chk("sat.start_lat", 64'(e), 64'd4);
    tick();
    repeat (10) tick();
    chk("sat.cycles10", 64'(bus_b.cycles), 64'd10);
    repeat (5) tick();
    chk("sat.cycles15", 64'(bus_b.cycles), 64'd15);
    repeat (5) tick();
    chk("sat.cycles_hold", 64'(bus_b.cycles), 64'd15);
    chk("sat.flags", 64'({bus_b.start, bus_b.running, bus_b.finish, bus_b.pass, bus_b.timeout}),
        64'b01000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
